// File: rtl/core_adder_arb_pkg.sv
// rtl/core_adder_arb_pkg.sv - shared types and defaults for the shared-adder arbiter
package core_adder_arb_pkg;

  localparam int ARB_XLEN    = 64;
  localparam int ARB_NUM_REQ = 4;
  localparam int ARB_IDW     = $clog2(ARB_NUM_REQ);

  typedef logic [ARB_IDW-1:0] req_id_t;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/core_64bit_adder.sv
// rtl/core_64bit_adder.sv - plain modulo-2^W integer adder, carry-out discarded
module core_64bit_adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/core_rr_arbiter.sv
// rtl/core_rr_arbiter.sv - round-robin arbiter: first requester at or above i_ptr, wrapping
module core_rr_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_ptr,
  input  logic           i_enable,
  output logic [N-1:0]   o_grant,
  output logic [IDW-1:0] o_grant_idx,
  output logic           o_any_grant
);

  int w_idx;

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    w_idx       = 0;
    if (i_enable) begin
      for (int k = 0; k < N; k++) begin
        w_idx = (int'(i_ptr) + k) % N;
        // Only the first hit in search order wins, keeping the grant one-hot.
        if (!o_any_grant && i_req[w_idx]) begin
          o_any_grant    = 1'b1;
          o_grant[w_idx] = 1'b1;
          o_grant_idx    = IDW'(w_idx);
        end
      end
    end
  end

endmodule

// File: rtl/core_adder_share_arb.sv
// rtl/core_adder_share_arb.sv - one adder shared by NUM_REQ requesters with a registered,
// tagged response slot that can be refilled in the same cycle it drains
module core_adder_share_arb
  import core_adder_arb_pkg::*;
#(
  parameter  int XLEN    = ARB_XLEN,
  parameter  int NUM_REQ = ARB_NUM_REQ,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  i_req_srcA,
  input  logic [NUM_REQ-1:0][XLEN-1:0]  i_req_srcB,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_rsp_valid,
  output logic [IDW-1:0]                o_rsp_id,
  output logic [XLEN-1:0]               o_rsp_result,
  input  logic                          i_rsp_ready
);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [IDW-1:0]      r_rr_ptr;
  logic [IDW-1:0]      w_rr_ptr_nxt;
  logic [IDW-1:0]      r_rsp_id;
  logic [XLEN-1:0]     r_rsp_result;

  logic                w_can_accept;
  logic [NUM_REQ-1:0]  w_grant;
  logic [IDW-1:0]      w_grant_idx;
  logic                w_any_grant;
  logic [XLEN-1:0]     w_opa;
  logic [XLEN-1:0]     w_opb;
  logic [XLEN-1:0]     w_sum;

  // Gating with i_rst_n keeps every ready low while reset is asserted.
  assign w_can_accept = i_rst_n & ((r_state == ARB_EMPTY) | i_rsp_ready);

  core_rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .i_req       (i_req_valid),
    .i_ptr       (r_rr_ptr),
    .i_enable    (w_can_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_grant (w_any_grant)
  );

  assign w_opa = i_req_srcA[w_grant_idx];
  assign w_opb = i_req_srcB[w_grant_idx];

  core_64bit_adder #(
    .W (XLEN)
  ) u_add (
    .i_a   (w_opa),
    .i_b   (w_opb),
    .o_sum (w_sum)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_rr_ptr_nxt = r_rr_ptr;
    if (w_any_grant) begin
      w_state_nxt  = ARB_FULL;
      w_rr_ptr_nxt = (w_grant_idx == IDW'(NUM_REQ - 1)) ? '0 : w_grant_idx + IDW'(1);
    end else if ((r_state == ARB_FULL) && i_rsp_ready) begin
      w_state_nxt = ARB_EMPTY;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= ARB_EMPTY;
      r_rr_ptr <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // Result and id are not cleared on drain; they hold until the next accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
    end else if (w_any_grant) begin
      r_rsp_id     <= w_grant_idx;
      r_rsp_result <= w_sum;
    end
  end

  assign o_req_ready  = w_grant;
  assign o_rsp_valid  = (r_state == ARB_FULL);
  assign o_rsp_id     = r_rsp_id;
  assign o_rsp_result = r_rsp_result;

endmodule

// File: tb/tb_core_adder_share_arb.sv
// tb/tb_core_adder_share_arb.sv - self-checking bench for core_adder_share_arb
module tb_core_adder_share_arb;

  localparam int N    = 4;
  localparam int XLEN = 64;

  logic                    i_clk = 1'b0;
  logic                    i_rst_n;
  logic [N-1:0]            i_req_valid;
  logic [N-1:0][XLEN-1:0]  i_req_srcA;
  logic [N-1:0][XLEN-1:0]  i_req_srcB;
  logic [N-1:0]            o_req_ready;
  logic                    o_rsp_valid;
  logic [1:0]              o_rsp_id;
  logic [XLEN-1:0]         o_rsp_result;
  logic                    i_rsp_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: response slot contents and round-robin start point.
  bit          m_full;
  int          m_id;
  logic [63:0] m_res;
  int          m_ptr;

  typedef struct {
    logic [3:0]  valid;
    logic [63:0] a;
    logic [63:0] b;
    logic        rr;
    logic [3:0]  exp_ready;
    logic        exp_vld;
    int          exp_id;
    logic [63:0] exp_res;
  } vec_t;

  vec_t vecs[11];

  core_adder_share_arb dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_req_valid  (i_req_valid),
    .i_req_srcA   (i_req_srcA),
    .i_req_srcB   (i_req_srcB),
    .o_req_ready  (o_req_ready),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_id     (o_rsp_id),
    .o_rsp_result (o_rsp_result),
    .i_rsp_ready  (i_rsp_ready)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_id   = 0;
    m_res  = '0;
    m_ptr  = 0;
  endtask

  function automatic logic [3:0] model_ready(input logic [3:0] v, input logic rr);
    if (!m_full || rr) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (v[j]) return 4'(1 << j);
      end
    end
    return 4'b0000;
  endfunction

  task automatic model_step(input logic [3:0] g);
    if (g != 4'b0000) begin
      for (int i = 0; i < N; i++) begin
        if (g[i]) begin
          m_full = 1'b1;
          m_id   = i;
          m_res  = i_req_srcA[i] + i_req_srcB[i];
          m_ptr  = (i + 1) % N;
        end
      end
    end else if (m_full && i_rsp_ready) begin
      m_full = 1'b0;
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [63:0] a, input logic [63:0] b,
                       input logic rr);
    i_req_valid = v;
    for (int i = 0; i < N; i++) begin
      i_req_srcA[i] = a + 64'(i);
      i_req_srcB[i] = b;
    end
    i_rsp_ready = rr;
  endtask

  // Called at posedge+1 with inputs applied; returns at the following posedge+1.
  task automatic run_cycle(output logic [3:0] rdy);
    logic [3:0] er;
    #3;
    er  = model_ready(i_req_valid, i_rsp_ready);
    rdy = o_req_ready;
    check("req_ready_model", 64'(o_req_ready), 64'(er));
    @(posedge i_clk);
    model_step(er);
    #1;
    check("rsp_valid_model", 64'(o_rsp_valid), 64'(m_full));
    check("rsp_id_model", 64'(o_rsp_id), 64'(m_id));
    check("rsp_result_model", o_rsp_result, m_res);
  endtask

  initial begin
    logic [3:0] rdy;

    // round robin from reset, then single adds, wrap, hold, drain, idle rsp_ready
    vecs[0]  = '{4'b1111, 64'h100, 64'h10, 1'b1, 4'b0001, 1'b1, 0, 64'h110};
    vecs[1]  = '{4'b1111, 64'h100, 64'h10, 1'b1, 4'b0010, 1'b1, 1, 64'h111};
    vecs[2]  = '{4'b1111, 64'h100, 64'h10, 1'b1, 4'b0100, 1'b1, 2, 64'h112};
    vecs[3]  = '{4'b1111, 64'h100, 64'h10, 1'b1, 4'b1000, 1'b1, 3, 64'h113};
    vecs[4]  = '{4'b1111, 64'h100, 64'h10, 1'b1, 4'b0001, 1'b1, 0, 64'h110};
    vecs[5]  = '{4'b0000, 64'h0,   64'h0,  1'b1, 4'b0000, 1'b0, 0, 64'h110};
    vecs[6]  = '{4'b0001, 64'h5,   64'h7,  1'b1, 4'b0001, 1'b1, 0, 64'hC};
    vecs[7]  = '{4'b0001, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 1'b1, 4'b0001, 1'b1, 0, 64'h1};
    vecs[8]  = '{4'b0000, 64'h0,   64'h0,  1'b0, 4'b0000, 1'b1, 0, 64'h1};
    vecs[9]  = '{4'b0000, 64'h0,   64'h0,  1'b1, 4'b0000, 1'b0, 0, 64'h1};
    vecs[10] = '{4'b0010, 64'h20,  64'h3,  1'b0, 4'b0010, 1'b1, 1, 64'h24};

    // reset with all requesters valid
    i_rst_n = 1'b0;
    drive(4'b1111, 64'h1, 64'h1, 1'b1);
    model_reset();
    #2;
    check("rst_req_ready", 64'(o_req_ready), 64'h0);
    check("rst_rsp_valid", 64'(o_rsp_valid), 64'h0);
    check("rst_rsp_id", 64'(o_rsp_id), 64'h0);
    check("rst_rsp_result", o_rsp_result, 64'h0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    for (int t = 0; t < 11; t++) begin
      drive(vecs[t].valid, vecs[t].a, vecs[t].b, vecs[t].rr);
      run_cycle(rdy);
      check($sformatf("vec%0d_ready", t), 64'(rdy), 64'(vecs[t].exp_ready));
      check($sformatf("vec%0d_valid", t), 64'(o_rsp_valid), 64'(vecs[t].exp_vld));
      check($sformatf("vec%0d_id", t), 64'(o_rsp_id), 64'(vecs[t].exp_id));
      check($sformatf("vec%0d_result", t), o_rsp_result, vecs[t].exp_res);
    end

    // backpressure: slot holds id 2 / 0x10 while req1 waits, then drains with no bubble
    drive(4'b0000, 64'h0, 64'h0, 1'b1);
    run_cycle(rdy);
    drive(4'b0100, 64'h6, 64'h8, 1'b1);
    run_cycle(rdy);
    check("bp_fill_id", 64'(o_rsp_id), 64'h2);
    check("bp_fill_result", o_rsp_result, 64'h10);
    drive(4'b0010, 64'h2F, 64'h1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      run_cycle(rdy);
      check($sformatf("bp_hold%0d_ready", c), 64'(rdy), 64'h0);
      check($sformatf("bp_hold%0d_valid", c), 64'(o_rsp_valid), 64'h1);
      check($sformatf("bp_hold%0d_id", c), 64'(o_rsp_id), 64'h2);
      check($sformatf("bp_hold%0d_result", c), o_rsp_result, 64'h10);
    end
    i_rsp_ready = 1'b1;
    run_cycle(rdy);
    check("bp_release_ready", 64'(rdy), 64'h2);
    check("bp_release_valid", 64'(o_rsp_valid), 64'h1);
    check("bp_release_id", 64'(o_rsp_id), 64'h1);
    check("bp_release_result", o_rsp_result, 64'h31);

    // asynchronous reset while holding 0xAB
    drive(4'b0001, 64'hAB, 64'h0, 1'b1);
    run_cycle(rdy);
    check("mr_fill_result", o_rsp_result, 64'hAB);
    drive(4'b1111, 64'h3, 64'h3, 1'b0);
    #2;
    i_rst_n = 1'b0;
    model_reset();
    #1;
    check("mr_rsp_valid", 64'(o_rsp_valid), 64'h0);
    check("mr_rsp_id", 64'(o_rsp_id), 64'h0);
    check("mr_rsp_result", o_rsp_result, 64'h0);
    check("mr_req_ready", 64'(o_req_ready), 64'h0);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    drive(4'b1111, 64'h40, 64'h1, 1'b1);
    run_cycle(rdy);
    check("mr_after_ready", 64'(rdy), 64'h1);
    check("mr_after_id", 64'(o_rsp_id), 64'h0);
    check("mr_after_result", o_rsp_result, 64'h41);

    // randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      i_req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        i_req_srcA[i] = {$urandom, $urandom};
        i_req_srcB[i] = {$urandom, $urandom};
      end
      i_rsp_ready = ($urandom_range(0, 3) != 0);
      run_cycle(rdy);
      check("rand_onehot", 64'($countones(rdy) <= 1), 64'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
